// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register-file geometry and the writeback entry type.
package cpu_pkg;

  localparam int REG_W    = 16;
  localparam int REG_AW   = 3;
  localparam int NUM_REGS = 8;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [REG_W-1:0]  data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback entries. A push and a pop in the same cycle
// are both honoured. The caller never pushes when full or pops when empty.
module wb_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  wb_entry_t push_entry,
  input  logic      pop,
  output wb_entry_t head,
  output logic      full,
  output logic      empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  wb_entry_t          mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W:0]     count;

  // Storage array; data only, so it carries no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == (PTR_W+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/wb_unit.sv
// Writeback unit: sole master of the register-file write port. ALU results
// always take the port; load results queue in a small FIFO and drain in
// ALU-idle cycles. A pending-load scoreboard exposes RAW/WAW hazards to issue.
// Optional build macro WB_LOAD_BYPASS_EN: a load arriving when the FIFO is
// empty and the ALU is idle is written one cycle after acceptance, skipping
// the FIFO.
module wb_unit
  import cpu_pkg::*;
#(
  parameter int LQ_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [REG_AW-1:0] alu_rd,
  input  logic [REG_W-1:0]  alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [REG_W-1:0]  mem_data,
  input  logic              iss_load,
  input  logic [REG_AW-1:0] iss_rd,
  input  logic [REG_AW-1:0] chk_rs1,
  input  logic [REG_AW-1:0] chk_rs2,
  input  logic [REG_AW-1:0] chk_rd,
  output logic              hazard,
  output logic [NUM_REGS-1:0] pend,
  output logic              rd_we,
  output logic [REG_AW-1:0] rd,
  output logic [REG_W-1:0]  rd_data
);

  wb_entry_t             push_entry;
  wb_entry_t             head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  push;
  logic                  pop;
  logic                  bypass;
  logic [NUM_REGS-1:0]   pend_q;
  logic [NUM_REGS-1:0]   pend_nxt;

  // ---- stage p0: load acceptance, queue arbitration ----
  assign mem_ready = !rst && !fifo_full;

`ifdef WB_LOAD_BYPASS_EN
  assign bypass = mem_valid && mem_ready && fifo_empty && !alu_valid;
`else
  assign bypass = 1'b0;
`endif

  assign push = mem_valid && mem_ready && !bypass;
  assign pop  = !alu_valid && !fifo_empty;

  assign push_entry.rd   = mem_rd;
  assign push_entry.data = mem_data;

  wb_fifo #(
    .DEPTH (LQ_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  // ---- stage p1: registered write port ----
  // Priority: ALU, then FIFO head, then bypassed load; r0 writes are squashed.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_we   <= 1'b0;
      rd      <= '0;
      rd_data <= '0;
    end else if (alu_valid) begin
      rd_we   <= (alu_rd != '0);
      rd      <= alu_rd;
      rd_data <= alu_data;
    end else if (pop) begin
      rd_we   <= (head.rd != '0);
      rd      <= head.rd;
      rd_data <= head.data;
    end else if (bypass) begin
      rd_we   <= (mem_rd != '0);
      rd      <= mem_rd;
      rd_data <= mem_data;
    end else begin
      rd_we   <= 1'b0;
    end
  end

  // Scoreboard update: clear the register being written from a load, then
  // apply a new issue so that set wins a same-bit collision; r0 never pends.
  always_comb begin
    pend_nxt = pend_q;
    if (pop)      pend_nxt[head.rd] = 1'b0;
    if (bypass)   pend_nxt[mem_rd]  = 1'b0;
    if (iss_load) pend_nxt[iss_rd]  = 1'b1;
    pend_nxt[0] = 1'b0;
  end

  // Scoreboard register, aligned with the write-port register.
  always_ff @(posedge clk) begin
    if (rst) pend_q <= '0;
    else     pend_q <= pend_nxt;
  end

  assign pend   = pend_q;
  assign hazard = pend_q[chk_rs1] | pend_q[chk_rs2] | pend_q[chk_rd];

  // Issue must stall while its destination already has a load outstanding.
  a_no_double_issue : assert property (@(posedge clk) disable iff (rst)
    !(iss_load && pend_q[iss_rd]));

endmodule

// File: tb/tb_wb_unit.sv
// Directed bench for wb_unit with hand-computed expected values.
module tb_wb_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [2:0]  alu_rd;
  logic [15:0] alu_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [2:0]  mem_rd;
  logic [15:0] mem_data;
  logic        iss_load;
  logic [2:0]  iss_rd;
  logic [2:0]  chk_rs1;
  logic [2:0]  chk_rs2;
  logic [2:0]  chk_rd;
  logic        hazard;
  logic [7:0]  pend;
  logic        rd_we;
  logic [2:0]  rd;
  logic [15:0] rd_data;

  int checks   = 0;
  int failures = 0;

  wb_unit #(.LQ_DEPTH(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_rd    (mem_rd),
    .mem_data  (mem_data),
    .iss_load  (iss_load),
    .iss_rd    (iss_rd),
    .chk_rs1   (chk_rs1),
    .chk_rs2   (chk_rs2),
    .chk_rd    (chk_rd),
    .hazard    (hazard),
    .pend      (pend),
    .rd_we     (rd_we),
    .rd        (rd),
    .rd_data   (rd_data)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_wr(input string tag, input logic we, input logic [2:0] a, input logic [15:0] d);
    check({tag, "_we"}, {31'd0, rd_we}, {31'd0, we});
    check({tag, "_rd"}, {29'd0, rd}, {29'd0, a});
    check({tag, "_data"}, {16'd0, rd_data}, {16'd0, d});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
    iss_load = 1'b0; iss_rd = '0; chk_rs1 = '0; chk_rs2 = '0; chk_rd = '0;

    // reset state
    tick; tick;
    check_wr("rst", 1'b0, 3'd0, 16'h0000);
    check("rst_pend", {24'd0, pend}, 32'h0);
    check("rst_ready", {31'd0, mem_ready}, 32'd0);
    rst = 1'b0; settle;
    check("post_rst_ready", {31'd0, mem_ready}, 32'd1);
    check("post_rst_hazard", {31'd0, hazard}, 32'd0);

    // ALU only
    alu_valid = 1'b1; alu_rd = 3'd3; alu_data = 16'hBEEF;
    tick;
    check_wr("alu", 1'b1, 3'd3, 16'hBEEF);
    alu_valid = 1'b0;
    tick;
    check_wr("alu_idle", 1'b0, 3'd3, 16'hBEEF);

    // r0 suppression, ALU then load
    alu_valid = 1'b1; alu_rd = 3'd0; alu_data = 16'h1234;
    tick;
    check("alu_r0_we", {31'd0, rd_we}, 32'd0);
    alu_valid = 1'b0;
    mem_valid = 1'b1; mem_rd = 3'd0; mem_data = 16'h5555;
    tick;
    mem_valid = 1'b0;
    check("ld_r0_we_a", {31'd0, rd_we}, 32'd0);
    tick;
    check("ld_r0_we_b", {31'd0, rd_we}, 32'd0);
    settle;
    check("ld_r0_ready", {31'd0, mem_ready}, 32'd1);

    // ALU/load contention on r5 vs r2
    iss_load = 1'b1; iss_rd = 3'd5;
    tick;
    iss_load = 1'b0; chk_rs1 = 3'd5; settle;
    check("cont_pend0", {24'd0, pend}, 32'h20);
    check("cont_haz0", {31'd0, hazard}, 32'd1);
    mem_valid = 1'b1; mem_rd = 3'd5; mem_data = 16'h00AA;
    tick;
    mem_valid = 1'b0;
`ifdef WB_LOAD_BYPASS_EN
    check_wr("cont_byp", 1'b1, 3'd5, 16'h00AA);
    check("cont_byp_pend", {24'd0, pend}, 32'h0);
    alu_valid = 1'b1; alu_rd = 3'd2; alu_data = 16'h2222;
    tick;
    alu_valid = 1'b0;
    check_wr("cont_alu", 1'b1, 3'd2, 16'h2222);
`else
    check("cont_n1_we", {31'd0, rd_we}, 32'd0);
    check("cont_n1_pend", {24'd0, pend}, 32'h20);
    alu_valid = 1'b1; alu_rd = 3'd2; alu_data = 16'h2222;
    tick;
    alu_valid = 1'b0;
    check_wr("cont_alu", 1'b1, 3'd2, 16'h2222);
    check("cont_n2_pend", {24'd0, pend}, 32'h20);
    check("cont_n2_haz", {31'd0, hazard}, 32'd1);
    tick;
    check_wr("cont_ld", 1'b1, 3'd5, 16'h00AA);
    check("cont_n3_pend", {24'd0, pend}, 32'h0);
`endif
    settle;
    check("cont_haz_end", {31'd0, hazard}, 32'd0);
    chk_rs1 = 3'd0;

    // back-pressure with ALU holding the port
    iss_load = 1'b1; iss_rd = 3'd6;
    tick;
    iss_rd = 3'd7;
    tick;
    iss_load = 1'b0; chk_rd = 3'd7; settle;
    check("bp_pend0", {24'd0, pend}, 32'hC0);
    check("bp_haz0", {31'd0, hazard}, 32'd1);
    alu_valid = 1'b1; alu_rd = 3'd1; alu_data = 16'h1111;
    mem_valid = 1'b1; mem_rd = 3'd6; mem_data = 16'h0A01; settle;
    check("bp_rdy1", {31'd0, mem_ready}, 32'd1);
    tick;
    mem_rd = 3'd7; mem_data = 16'h0A02; settle;
    check("bp_rdy2", {31'd0, mem_ready}, 32'd1);
    tick;
    mem_rd = 3'd4; mem_data = 16'h0A03; settle;
    check("bp_full_a", {31'd0, mem_ready}, 32'd0);
    tick;
    check("bp_full_b", {31'd0, mem_ready}, 32'd0);
    check_wr("bp_alu", 1'b1, 3'd1, 16'h1111);
    alu_valid = 1'b0; settle;
    check("bp_full_pop", {31'd0, mem_ready}, 32'd0);
    tick;
    check_wr("bp_ld1", 1'b1, 3'd6, 16'h0A01);
    check("bp_pend1", {24'd0, pend}, 32'h80);
    settle;
    check("bp_rdy3", {31'd0, mem_ready}, 32'd1);
    tick;
    mem_valid = 1'b0;
    check_wr("bp_ld2", 1'b1, 3'd7, 16'h0A02);
    check("bp_pend2", {24'd0, pend}, 32'h0);
    tick;
    check_wr("bp_ld3", 1'b1, 3'd4, 16'h0A03);
    tick;
    check("bp_idle_we", {31'd0, rd_we}, 32'd0);
    chk_rd = 3'd0;

    // single load into an idle queue
    iss_load = 1'b1; iss_rd = 3'd4;
    tick;
    iss_load = 1'b0;
    check("byp_pend0", {24'd0, pend}, 32'h10);
    mem_valid = 1'b1; mem_rd = 3'd4; mem_data = 16'h4444;
    tick;
    mem_valid = 1'b0;
`ifdef WB_LOAD_BYPASS_EN
    check_wr("byp_n1", 1'b1, 3'd4, 16'h4444);
    check("byp_n1_pend", {24'd0, pend}, 32'h0);
`else
    check("byp_n1_we", {31'd0, rd_we}, 32'd0);
    check("byp_n1_pend", {24'd0, pend}, 32'h10);
    tick;
    check_wr("byp_n2", 1'b1, 3'd4, 16'h4444);
    check("byp_n2_pend", {24'd0, pend}, 32'h0);
`endif

    // reset mid-burst with two loads buffered
    iss_load = 1'b1; iss_rd = 3'd3;
    tick;
    iss_load = 1'b0;
    alu_valid = 1'b1; alu_rd = 3'd1; alu_data = 16'h0101;
    mem_valid = 1'b1; mem_rd = 3'd3; mem_data = 16'h00D1;
    tick;
    mem_data = 16'h00D2;
    tick;
    mem_valid = 1'b0; alu_valid = 1'b0; rst = 1'b1; settle;
    check("mid_rst_ready_a", {31'd0, mem_ready}, 32'd0);
    tick;
    check("mid_rst_we", {31'd0, rd_we}, 32'd0);
    check("mid_rst_pend", {24'd0, pend}, 32'h0);
    check("mid_rst_ready_b", {31'd0, mem_ready}, 32'd0);
    rst = 1'b0; settle;
    check("mid_rst_ready_c", {31'd0, mem_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick;
      check($sformatf("mid_rst_stale%0d", i), {31'd0, rd_we}, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_unit.md
Name: wb_unit

Overview:
- Writeback unit: the write-side master of the CPU's 8x16-bit register file. Drives its single write port (rd_we/rd/rd_data).
- Merges single-cycle ALU results with variable-latency load results from the memory stage. Load results are buffered in a small FIFO.
- Keeps a pending-load scoreboard so issue can stall on RAW/WAW hazards against outstanding loads.
- Sits between the execute/memory stages and the register file.

Parameters:
- LQ_DEPTH, 2, load-result FIFO entries (power of 2, >=2)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- alu_valid  in  1  ALU result valid this cycle; never stalled
- alu_rd  in  3  ALU destination register
- alu_data  in  16  ALU result
- mem_valid  in  1  load result offered
- mem_ready  out  1  load result accepted when mem_valid&&mem_ready
- mem_rd  in  3  load destination register
- mem_data  in  16  load data
- iss_load  in  1  load issued this cycle; marks iss_rd pending
- iss_rd  in  3  destination of issued load
- chk_rs1  in  3  issue-stage source 1 to check
- chk_rs2  in  3  issue-stage source 2 to check
- chk_rd  in  3  issue-stage destination to check
- hazard  out  1  any checked register pending
- pend  out  8  scoreboard bitmask; bit 0 always 0
- rd_we  out  1  register file write enable
- rd  out  3  register file write address
- rd_data  out  16  register file write data

Behaviour:
- Reset (rst high at posedge):
  - rd_we=0, rd=0, rd_data=0, pend=0, FIFO emptied.
  - mem_ready=0 while rst is high.
  - Reset mid-operation discards all buffered loads and pending bits.
- Outputs rd_we/rd/rd_data are registered.
- ALU path:
  - alu_valid in cycle N -> rd_we=1, rd=alu_rd, rd_data=alu_data in cycle N+1.
  - ALU always wins the write port.
- Load path:
  - mem_ready = !rst && !fifo_full. Combinational; independent of mem_valid.
  - Accepted load is pushed to the FIFO.
  - FIFO pops only in cycles with alu_valid=0. Popped entry drives the output register next cycle.
  - Minimum load latency: accept at N -> rd_we at N+2. Order among loads is preserved.
- Simultaneous events:
  - Push and pop in the same cycle are allowed, including when full: mem_ready stays 0 when full; pop frees a slot for the next cycle.
  - alu_valid with FIFO non-empty: ALU written, FIFO held.
- r0: any write with rd=0 (either path) yields rd_we=0 at that cycle. Popped r0 entries are still consumed.
- No write cycle -> rd_we=0; rd/rd_data hold their previous values.
- Scoreboard:
  - iss_load && iss_rd!=0 sets pend[iss_rd] at the next edge.
  - Popping a load clears pend[popped rd] at the same edge the output register loads.
  - Set and clear of the same bit in one cycle: set wins.
- hazard (combinational) = pend[chk_rs1] | pend[chk_rs2] | pend[chk_rd]; r0 checks contribute 0.
- Illegal stimulus, flagged by assertion: iss_load while pend[iss_rd] is already set (issue must stall on hazard).
- Width: 16-bit data, unchanged; no arithmetic on data.

Optional Feature:
- Macro WB_LOAD_BYPASS_EN.
- Defined: when FIFO empty, alu_valid=0 and mem_valid=1, the load goes straight to the output register. Write at N+1, no push; pend cleared at that edge.
- Undefined: all loads pass through the FIFO, minimum latency N+2.

Decomposition:
- cpu_pkg holds:
  - REG_W=16, REG_AW=3, NUM_REGS=8
  - typedef wb_entry_t {logic [REG_AW-1:0] rd; logic [REG_W-1:0] data;}
- Sub-module wb_fifo: parameterised sync FIFO of wb_entry_t with push/pop/full/empty. Simultaneous push+pop is legal.

Test Plan:
- Reset mid-burst: push 2 loads, assert rst 1 cycle -> rd_we=0, pend=0, mem_ready=0 during rst and 1 after; no stale writes appear.
- ALU only: alu_valid, alu_rd=3, alu_data=16'hBEEF at N -> rd_we=1, rd=3, rd_data=16'hBEEF at N+1, rd_we=0 at N+2.
- r0 suppression: alu_rd=0, data 16'h1234 -> rd_we=0. Same for a load to r0; that load is still popped.
- ALU/load contention:
  - iss_load rd=5, then mem load rd=5 data 16'h00AA at N, alu_valid rd=2 at N+1 -> r2 written at N+2, r5 at N+3.
  - pend[5]=1 until the N+3 edge; hazard=1 with chk_rs1=5 meanwhile.
- Back-pressure: LQ_DEPTH=2, alu_valid held high, 3 loads offered -> mem_ready=0 after 2 accepts. Drop alu_valid -> loads written in order, one per cycle, third accepted after the first pop.
- Bypass (WB_LOAD_BYPASS_EN): idle FIFO, load rd=4 at N -> write at N+1, pend[4] cleared at N+1. Without macro -> write at N+2.
